// File: rtl/bram_writer.sv
// Buffers producer words in a small FIFO and writes them to consecutive BRAM
// addresses, one write per cycle, for a session of numWrites words.
//
// state  | meaning
// s_idle | waiting for start; wordsWritten holds the last session's count
// s_run  | accepting words into the FIFO and strobing BRAM writes
// s_done | one-cycle done pulse, then back to s_idle
module bram_writer #(
    parameter int BRAM_ADDR_SIZE = 15,
    parameter int BRAM_DATA_SIZE = 32,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      clear,
    input  logic                      start,
    input  logic [15:0]               baseAddr,
    input  logic [15:0]               numWrites,
    input  logic                      inValid,
    input  logic [BRAM_DATA_SIZE-1:0] inData,
    input  logic                      testStallPop,
    output logic                      inReady,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               wordsWritten,
    output logic [BRAM_ADDR_SIZE-1:0] addr,
    output logic [BRAM_DATA_SIZE-1:0] writeData,
    output logic                      bramEnable,
    output logic                      bramWe
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        s_idle = 2'd0,
        s_run  = 2'd1,
        s_done = 2'd2
    } state_t;

    state_t                    state_q;
    logic [15:0]               num_q;
    logic [15:0]               accepted_q;
    logic [15:0]               written_q;
    logic [BRAM_ADDR_SIZE-1:0] next_addr_q;
    logic [BRAM_ADDR_SIZE-1:0] addr_q;
    logic [BRAM_DATA_SIZE-1:0] wdata_q;
    logic [BRAM_DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [PTR_W:0]            count_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      strobe_q;

    logic in_run;
    logic push;
    logic pop;

    assign in_run  = (state_q == s_run);
    assign inReady = in_run && (count_q != DEPTH_C) && (accepted_q < num_q);
    assign push    = inValid && inReady;
    // The stall hook only holds back pops; acceptance keeps filling the FIFO.
    assign pop     = in_run && (count_q != '0) && (written_q < num_q) && !testStallPop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= inData;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= s_idle;
            num_q       <= '0;
            accepted_q  <= '0;
            written_q   <= '0;
            next_addr_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            strobe_q    <= 1'b0;
        end else if (!clear) begin
            state_q    <= s_idle;
            accepted_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            strobe_q <= pop;
            done_q   <= 1'b0;

            if (pop) begin
                addr_q      <= next_addr_q;
                next_addr_q <= next_addr_q + 1'b1;
                wdata_q     <= mem_q[rd_ptr_q];
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                written_q   <= written_q + 16'd1;
            end

            if (push) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                accepted_q <= accepted_q + 16'd1;
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            case (state_q)
                s_idle: begin
                    if (start) begin
                        num_q       <= numWrites;
                        next_addr_q <= BRAM_ADDR_SIZE'(baseAddr);
                        accepted_q  <= '0;
                        written_q   <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= s_run;
                    end
                end
                s_run: begin
                    // Leaves one edge after the last strobe, so the final write is never cut short.
                    if (written_q == num_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= s_done;
                    end
                end
                s_done: begin
                    state_q <= s_idle;
                end
                default: begin
                    state_q <= s_idle;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign wordsWritten = written_q;
    assign addr         = addr_q;
    assign writeData    = wdata_q;
    assign bramEnable   = strobe_q;
    assign bramWe       = strobe_q;

endmodule

// File: tb/tb_bram_writer.sv
// Directed bench for bram_writer: a queue-fed producer, a strobe logger, and
// hand-computed expectations per session.
module tb_bram_writer;

    logic        clk = 1'b0;
    logic        resetN;
    logic        clear;
    logic        start;
    logic [15:0] baseAddr;
    logic [15:0] numWrites;
    logic        inValid;
    logic [31:0] inData;
    logic        testStallPop;
    logic        inReady;
    logic        busy;
    logic        done;
    logic [15:0] wordsWritten;
    logic [14:0] addr;
    logic [31:0] writeData;
    logic        bramEnable;
    logic        bramWe;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int rdy_cnt = 0;
    int fire_cnt = 0;
    bit fire = 1'b0;

    logic [31:0] src_q[$];
    logic [14:0] log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];

    bram_writer #(
        .BRAM_ADDR_SIZE(15),
        .BRAM_DATA_SIZE(32),
        .FIFO_DEPTH(16)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .clear(clear),
        .start(start),
        .baseAddr(baseAddr),
        .numWrites(numWrites),
        .inValid(inValid),
        .inData(inData),
        .testStallPop(testStallPop),
        .inReady(inReady),
        .busy(busy),
        .done(done),
        .wordsWritten(wordsWritten),
        .addr(addr),
        .writeData(writeData),
        .bramEnable(bramEnable),
        .bramWe(bramWe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Producer: a handshake seen during a cycle is retired at the following negedge.
    initial begin
        inValid = 1'b0;
        inData  = '0;
        forever begin
            @(negedge clk);
            if (fire && src_q.size() > 0) begin
                void'(src_q.pop_front());
                fire_cnt++;
            end
            if (src_q.size() > 0) begin
                inValid = 1'b1;
                inData  = src_q[0];
            end else begin
                inValid = 1'b0;
            end
            fire = inValid && inReady;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bramEnable || bramWe) begin
                chk("en_eq_we", {31'd0, bramWe}, {31'd0, bramEnable});
            end
            if (bramEnable) begin
                log_addr.push_back(addr);
                log_data.push_back(writeData);
                log_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (inReady) rdy_cnt++;
        end
    end

    task automatic clr_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        done_cnt = 0;
        rdy_cnt  = 0;
        fire_cnt = 0;
    endtask

    task automatic run_start(input logic [15:0] base, input logic [15:0] n);
        @(negedge clk);
        baseAddr  = base;
        numWrites = n;
        start     = 1'b1;
        @(negedge clk);
        start_cyc = cyc;
        start     = 1'b0;
        baseAddr  = 16'hFFFF;
        numWrites = 16'hFFFF;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (done_cnt == 0 && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, {31'd0, (done_cnt != 0)}, 32'd1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        resetN       = 1'b0;
        clear        = 1'b1;
        start        = 1'b0;
        baseAddr     = '0;
        numWrites    = '0;
        testStallPop = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_inReady", {31'd0, inReady}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_en", {31'd0, bramEnable}, 32'd0);
        chk("rst_addr", {17'd0, addr}, 32'd0);
        chk("rst_wdata", writeData, 32'd0);
        chk("rst_count", {16'd0, wordsWritten}, 32'd0);
        resetN = 1'b1;
        @(negedge clk);

        // Basic four-word session
        clr_log();
        for (int i = 0; i < 4; i++) src_q.push_back(32'hA0 + i);
        run_start(16'h0010, 16'd4);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_done("t1_done_seen", 40);
        chk("t1_nstrobes", log_addr.size(), 32'd4);
        if (log_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_addr", {17'd0, log_addr[i]}, 32'h10 + i);
                chk("t1_data", log_data[i], 32'hA0 + i);
            end
            chk("t1_first_lat", log_cyc[0], start_cyc + 2);
            chk("t1_consec", log_cyc[3], log_cyc[0] + 3);
        end
        chk("t1_done_cyc", done_cyc, start_cyc + 6);
        chk("t1_done_once", done_cnt, 32'd1);
        chk("t1_words", {16'd0, wordsWritten}, 32'd4);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);

        // Address wrap at the top of the 15-bit space
        clr_log();
        for (int i = 0; i < 4; i++) src_q.push_back(32'hB0 + i);
        run_start(16'h7FFE, 16'd4);
        wait_done("t2_done_seen", 40);
        chk("t2_nstrobes", log_addr.size(), 32'd4);
        if (log_addr.size() == 4) begin
            chk("t2_addr0", {17'd0, log_addr[0]}, 32'h7FFE);
            chk("t2_addr1", {17'd0, log_addr[1]}, 32'h7FFF);
            chk("t2_addr2", {17'd0, log_addr[2]}, 32'h0000);
            chk("t2_addr3", {17'd0, log_addr[3]}, 32'h0001);
            chk("t2_data3", log_data[3], 32'hB3);
        end

        // Zero-length session
        clr_log();
        src_q.push_back(32'hDEAD);
        run_start(16'h0040, 16'd0);
        wait_done("t3_done_seen", 20);
        chk("t3_nstrobes", log_addr.size(), 32'd0);
        chk("t3_rdy_cycles", rdy_cnt, 32'd0);
        chk("t3_done_cyc", done_cyc, start_cyc + 1);
        chk("t3_words", {16'd0, wordsWritten}, 32'd0);
        src_q.delete();
        @(negedge clk);

        // Backpressure: pops stalled until the FIFO fills
        clr_log();
        testStallPop = 1'b1;
        for (int i = 0; i < 40; i++) src_q.push_back(32'hC000_0000 + i);
        run_start(16'h0200, 16'd40);
        repeat (20) @(negedge clk);
        #1;
        chk("t4_fill_count", fire_cnt, 32'd16);
        chk("t4_ready_full", {31'd0, inReady}, 32'd0);
        chk("t4_no_strobe", log_addr.size(), 32'd0);
        testStallPop = 1'b0;
        wait_done("t4_done_seen", 200);
        chk("t4_nstrobes", log_addr.size(), 32'd40);
        if (log_addr.size() == 40) begin
            for (int i = 0; i < 40; i++) begin
                chk("t4_data", log_data[i], 32'hC000_0000 + i);
                chk("t4_addr", {17'd0, log_addr[i]}, 32'h200 + i);
            end
        end
        chk("t4_words", {16'd0, wordsWritten}, 32'd40);

        // Abort via clear after three writes, then a fresh session
        clr_log();
        for (int i = 0; i < 10; i++) src_q.push_back(32'hD0 + i);
        run_start(16'h0100, 16'd10);
        begin
            int n = 0;
            while (log_addr.size() < 3 && n < 40) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        chk("t5_reached3", log_addr.size(), 32'd3);
        clear = 1'b0;
        @(negedge clk);
        #1;
        clear = 1'b1;
        src_q.delete();
        chk("t5_ready", {31'd0, inReady}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        #1;
        chk("t5_nstrobes", log_addr.size(), 32'd3);
        chk("t5_no_done", done_cnt, 32'd0);
        chk("t5_words", {16'd0, wordsWritten}, 32'd3);
        clr_log();
        src_q.push_back(32'hE0);
        src_q.push_back(32'hE1);
        run_start(16'h0020, 16'd2);
        wait_done("t5b_done_seen", 40);
        chk("t5b_nstrobes", log_addr.size(), 32'd2);
        if (log_addr.size() == 2) begin
            chk("t5b_addr1", {17'd0, log_addr[1]}, 32'h21);
            chk("t5b_data0", log_data[0], 32'hE0);
        end
        chk("t5b_words", {16'd0, wordsWritten}, 32'd2);

        // Reset mid-session with five words buffered
        clr_log();
        testStallPop = 1'b1;
        for (int i = 0; i < 5; i++) src_q.push_back(32'hF0 + i);
        run_start(16'h0300, 16'd10);
        repeat (10) @(negedge clk);
        #1;
        chk("t6_buffered", fire_cnt, 32'd5);
        resetN = 1'b0;
        @(negedge clk);
        #1;
        resetN       = 1'b1;
        testStallPop = 1'b0;
        chk("t6_inReady", {31'd0, inReady}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        chk("t6_en", {31'd0, bramEnable}, 32'd0);
        chk("t6_addr", {17'd0, addr}, 32'd0);
        chk("t6_wdata", writeData, 32'd0);
        chk("t6_words", {16'd0, wordsWritten}, 32'd0);
        repeat (10) @(negedge clk);
        #1;
        chk("t6_no_strobe", log_addr.size(), 32'd0);
        chk("t6_no_done", done_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
